// File: rtl/fir_mac_seq.sv
// Sequential single-multiplier FIR filter.
// Each accepted sample shifts the delay line, then TAPS cycles of
// multiply-accumulate produce one rounded, saturated output.
module fir_mac_seq #(
  parameter  int WIDTH  = 16,
  parameter  int TAPS   = 17,
  parameter  int COEF_W = 16,
  parameter  int FRAC   = 16,
  localparam int AW     = $clog2(TAPS),
  localparam int ACC_W  = WIDTH + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [WIDTH-1:0]  data_i,
  input  logic                     coef_we_i,
  input  logic        [AW-1:0]     coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic                     out_valid_o,
  output logic signed [WIDTH-1:0]  data_o,
  output logic                     ovf_o,
  output logic                     busy_o
);

  localparam int PW = WIDTH + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, MAC} state_t;

  state_t                    state;
  logic        [AW-1:0]      idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [WIDTH-1:0]   buff [TAPS];
  logic signed [COEF_W-1:0]  coef [TAPS];

  logic signed [COEF_W-1:0]  coef_sel_p0;
  logic signed [WIDTH-1:0]   samp_sel_p0;
  logic signed [PW-1:0]      prod_p0;
  logic signed [ACC_W-1:0]   acc_sum_p0;
  logic signed [ACC_W:0]     rnd_p0;
  logic        [WIDTH:0]     sat_p0;
  logic                      addr_ok;

  // Round half up: add one half LSB of the output, then arithmetic shift.
  // One extra bit of headroom keeps the bias add from wrapping.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = {a[ACC_W-1], a} + HALF;
    return t >>> FRAC;
  endfunction

  // Clip to the output range; MSB of the result flags that clipping happened.
  function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W:0] v);
    if (v > MAXV)      return {1'b1, MAXV[WIDTH-1:0]};
    else if (v < MINV) return {1'b1, MINV[WIDTH-1:0]};
    else               return {1'b0, v[WIDTH-1:0]};
  endfunction

  // Stage p0: tap select, the single multiplier, accumulate and output shaping
  assign coef_sel_p0 = coef[idx];
  assign samp_sel_p0 = buff[idx];
  assign prod_p0     = coef_sel_p0 * samp_sel_p0;
  assign acc_sum_p0  = acc + {{(ACC_W-PW){prod_p0[PW-1]}}, prod_p0};
  assign rnd_p0      = round_shift(acc_sum_p0);
  assign sat_p0      = saturate(rnd_p0);

  assign addr_ok     = ({1'b0, coef_addr_i} < (AW+1)'(TAPS));
  assign in_ready_o  = (state == IDLE) && !rst;
  assign busy_o      = (state == MAC);

  // Control FSM, delay line, coefficient store and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      out_valid_o <= 1'b0;
      data_o      <= '0;
      ovf_o       <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        buff[k] <= '0;
        coef[k] <= '0;
      end
    end else begin
      out_valid_o <= 1'b0;
      // Coefficient RAM only updates while idle, so a running sum never mixes sets
      if (coef_we_i && (state == IDLE) && addr_ok)
        coef[coef_addr_i] <= coef_i;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            buff[0] <= data_i;
            for (int k = 1; k < TAPS; k++) buff[k] <= buff[k-1];
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum_p0;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state       <= IDLE;
            data_o      <= sat_p0[WIDTH-1:0];
            ovf_o       <= sat_p0[WIDTH];
            out_valid_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: 4-tap, 16-bit, FRAC=15 configuration against a
// behavioural convolution model with rounding and saturation.
module tb_fir_mac_seq;
  localparam int WIDTH = 16, TAPS = 4, COEF_W = 16, FRAC = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [WIDTH-1:0] data_in = '0;
  logic coef_we = 1'b0;
  logic [1:0] coef_addr = '0;
  logic signed [COEF_W-1:0] coef_val = '0;
  logic out_valid;
  logic signed [WIDTH-1:0] data_out;
  logic ovf;
  logic busy;

  int checks = 0;
  int passes = 0;

  int m_hist [TAPS];
  int m_coef [TAPS];
  int m_exp;
  bit m_ovf;

  fir_mac_seq #(.WIDTH(WIDTH), .TAPS(TAPS), .COEF_W(COEF_W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_i(data_in), .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_i(coef_val),
    .out_valid_o(out_valid), .data_o(data_out), .ovf_o(ovf), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference: direct convolution of the last TAPS samples, round half up, clip.
  function automatic void model_accept(input int s);
    longint acc, r;
    for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(m_coef[k]) * longint'(m_hist[k]);
    r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
    m_ovf = 1'b0;
    if (r > 32767) begin r = 32767; m_ovf = 1'b1; end
    else if (r < -32768) begin r = -32768; m_ovf = 1'b1; end
    m_exp = int'(r);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) begin m_hist[k] = 0; m_coef[k] = 0; end
  endfunction

  function automatic int rand16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input int a, input int v);
    int w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    coef_we = 1'b1; coef_addr = 2'(a); coef_val = 16'(v);
    @(posedge clk); #1;
    coef_we = 1'b0;
    m_coef[a] = v;
  endtask

  // Drives one sample, returns the result and the edge count from acceptance to the pulse.
  task automatic run_sample(input int s, output int got, output bit ov, output int lat);
    int w = 0;
    in_valid = 1'b1; data_in = 16'(s);
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(s);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
    got = int'(data_out); ov = ovf;
  endtask

  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", in_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (data_out !== 16'sd0) $display("FAIL reset_data got=%0d exp=0", data_out); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passes++;
    do_reset();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", in_ready); else passes++;
  endtask

  task automatic test_write_accept_same_edge();
    int lat;
    do_reset();
    coef_we = 1'b1; coef_addr = 2'd0; coef_val = 16'sd32767;
    in_valid = 1'b1; data_in = 16'sd16384;
    @(posedge clk); #1;
    coef_we = 1'b0; in_valid = 1'b0;
    wait_pulse(lat);
    checks++; if (lat !== TAPS) $display("FAIL same_edge_latency got=%0d exp=%0d", lat, TAPS); else passes++;
    checks++; if (int'(data_out) !== 16384) $display("FAIL same_edge_data got=%0d exp=16384", data_out); else passes++;
  endtask

  task automatic test_impulse();
    int exp_tab [5] = '{8192, 4096, 2048, -2048, 0};
    int samp [5] = '{16384, 0, 0, 0, 0};
    int got, lat, held;
    bit ov;
    do_reset();
    write_coef(0, 16384); write_coef(1, 8192); write_coef(2, 4096); write_coef(3, -4096);
    for (int i = 0; i < 5; i++) begin
      run_sample(samp[i], got, ov, lat);
      checks++; if (got !== exp_tab[i]) $display("FAIL impulse_data[%0d] got=%0d exp=%0d", i, got, exp_tab[i]); else passes++;
      checks++; if (ov !== 1'b0) $display("FAIL impulse_ovf[%0d] got=%b exp=0", i, ov); else passes++;
      checks++; if (lat !== TAPS) $display("FAIL impulse_latency[%0d] got=%0d exp=%0d", i, lat, TAPS); else passes++;
      if (i == 3) begin
        held = got;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL hold_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (int'(data_out) !== held) $display("FAIL hold_data got=%0d exp=%0d", data_out, held); else passes++;
      end
    end
  endtask

  task automatic test_rounding();
    int samp [4] = '{16384, -16384, 16383, -16385};
    int exp_tab [4] = '{1, 0, 0, -1};
    int got, lat;
    bit ov;
    write_coef(0, 1); write_coef(1, 0); write_coef(2, 0); write_coef(3, 0);
    for (int i = 0; i < 4; i++) begin
      run_sample(samp[i], got, ov, lat);
      checks++; if (got !== exp_tab[i]) $display("FAIL round[%0d] got=%0d exp=%0d", i, got, exp_tab[i]); else passes++;
      checks++; if (got !== m_exp) $display("FAIL round_model[%0d] got=%0d exp=%0d", i, got, m_exp); else passes++;
    end
  endtask

  task automatic test_saturation();
    int got, lat;
    bit ov;
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int i = 0; i < 8; i++) begin
      run_sample((i < 4) ? 32767 : -32768, got, ov, lat);
      checks++; if (got !== m_exp || ov !== m_ovf) $display("FAIL sat_model[%0d] got=%0d/%b exp=%0d/%b", i, got, ov, m_exp, m_ovf); else passes++;
      if (i == 3) begin
        checks++; if (got !== 32767 || ov !== 1'b1) $display("FAIL sat_pos got=%0d/%b exp=32767/1", got, ov); else passes++;
      end
      if (i == 7) begin
        checks++; if (got !== -32768 || ov !== 1'b1) $display("FAIL sat_neg got=%0d/%b exp=-32768/1", got, ov); else passes++;
      end
    end
  endtask

  task automatic test_busy_coef_write();
    int got, lat, s;
    bit ov;
    write_coef(0, 5000); write_coef(1, -7000); write_coef(2, 3000); write_coef(3, 11000);
    s = rand16();
    in_valid = 1'b1; data_in = 16'(s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(s);
    checks++; if (busy !== 1'b1) $display("FAIL busy_in_mac got=%b exp=1", busy); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL ready_in_mac got=%b exp=0", in_ready); else passes++;
    coef_we = 1'b1; coef_addr = 2'd0; coef_val = 16'sd100;
    @(posedge clk); #1;
    coef_we = 1'b0;
    wait_pulse(lat);
    checks++; if (int'(data_out) !== m_exp) $display("FAIL busy_write_result got=%0d exp=%0d", data_out, m_exp); else passes++;
    run_sample(rand16(), got, ov, lat);
    checks++; if (got !== m_exp) $display("FAIL busy_write_next got=%0d exp=%0d", got, m_exp); else passes++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0, readies = 0, s, e [3];
    s = rand16();
    for (int i = 0; i < 3; i++) begin model_accept(s); e[i] = m_exp; end
    in_valid = 1'b1; data_in = 16'(s);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (in_ready) readies++;
      if (out_valid) begin
        checks++; if ((c % (TAPS + 1)) != 0 || pulses > 2) $display("FAIL b2b_pulse_cycle got=%0d exp=multiple_of_%0d", c, TAPS + 1); else passes++;
        if (pulses <= 2) begin
          checks++; if (int'(data_out) !== e[pulses]) $display("FAIL b2b_data[%0d] got=%0d exp=%0d", pulses, data_out, e[pulses]); else passes++;
        end
        pulses++;
      end
    end
    in_valid = 1'b0;
    checks++; if (pulses !== 3) $display("FAIL b2b_pulse_count got=%0d exp=3", pulses); else passes++;
    checks++; if (readies !== 3) $display("FAIL b2b_ready_count got=%0d exp=3", readies); else passes++;
  endtask

  task automatic test_random();
    int got, lat;
    bit ov;
    for (int k = 0; k < TAPS; k++) write_coef(k, rand16());
    for (int i = 0; i < 12; i++) begin
      run_sample(rand16(), got, ov, lat);
      checks++; if (got !== m_exp || ov !== m_ovf || lat !== TAPS)
        $display("FAIL random[%0d] got=%0d/%b/lat%0d exp=%0d/%b/lat%0d", i, got, ov, lat, m_exp, m_ovf, TAPS); else passes++;
    end
  endtask

  task automatic test_reset_mid_mac();
    int got, lat, seen = 0;
    bit ov;
    write_coef(0, 12000); write_coef(1, 9000);
    in_valid = 1'b1; data_in = 16'sd20000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++; if (data_out !== 16'sd0 || ovf !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL midmac_outputs got=%0d/%b/%b/%b exp=0/0/0/0", data_out, ovf, busy, out_valid); else passes++;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (out_valid) seen++; end
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 5; c++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) $display("FAIL midmac_no_pulse got=%0d exp=0", seen); else passes++;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midmac_idle got=%b/%b exp=1/0", in_ready, busy); else passes++;
    run_sample(16384, got, ov, lat);
    checks++; if (got !== 0 || lat !== TAPS) $display("FAIL midmac_impulse got=%0d/lat%0d exp=0/lat%0d", got, lat, TAPS); else passes++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_accept_same_edge();
    test_impulse();
    test_rounding();
    test_saturation();
    test_busy_coef_write();
    test_back_to_back();
    test_random();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 Parameter WIDTH, default 16, is the signed sample and output width.
REQ-002 Parameter TAPS, default 17, is the filter length; legal range 2..64.
REQ-003 Parameter COEF_W, default 16, is the signed coefficient width.
REQ-004 Parameter FRAC, default 16, is the number of fractional result bits removed before output; legal range 1..(WIDTH+COEF_W-2).
REQ-005 Derived AW = clog2(TAPS) and ACC_W = WIDTH+COEF_W+clog2(TAPS) SHALL size the coefficient address and the accumulator.
REQ-006 Clocking: one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 in_valid_i  in  1  data_i holds a sample.
REQ-010 in_ready_o  out  1  block accepts a sample this cycle.
REQ-011 data_i  in  WIDTH  signed input sample.
REQ-012 coef_we_i  in  1  coefficient write strobe.
REQ-013 coef_addr_i  in  AW  coefficient index 0..TAPS-1.
REQ-014 coef_i  in  COEF_W  signed coefficient value.
REQ-015 out_valid_o  out  1  one-cycle pulse, data_o valid.
REQ-016 data_o  out  WIDTH  signed filtered output, held between pulses.
REQ-017 ovf_o  out  1  saturation occurred on the current result; valid with out_valid_o.
REQ-018 busy_o  out  1  high in MAC state.

Function
REQ-019 FSM SHALL have states IDLE and MAC; in_ready_o = (state==IDLE), busy_o = (state==MAC).
REQ-020 Acceptance = in_valid_i & in_ready_o at a rising edge: delay line shifts (buff[0]<=data_i, buff[k]<=buff[k-1]), accumulator clears, tap index clears, FSM enters MAC.
REQ-021 In MAC, each edge SHALL add coef[idx]*buff[idx] (full signed product, sign-extended to ACC_W) into the accumulator and increment idx; exactly one multiplier instance.
REQ-022 On the edge with idx==TAPS-1 the FSM SHALL return to IDLE and register the final result into data_o/ovf_o with out_valid_o high for the next cycle only.
REQ-023 Latency: sample accepted at edge n gives out_valid_o high between edges n+TAPS and n+TAPS+1; in_ready_o is high in that same cycle, so peak throughput is one sample per TAPS+1 cycles.
REQ-024 in_valid_i while in MAC SHALL be ignored (no buffering); the source holds the sample until in_ready_o.
REQ-025 Result = (acc + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; ovf_o = 1 iff clipping occurred.
REQ-026 The accumulator SHALL never wrap for any input/coefficient values at legal parameters.
REQ-027 Coefficient write with coef_we_i high SHALL take effect at the edge only when state==IDLE and coef_addr_i<TAPS; otherwise it is dropped.
REQ-028 Simultaneous acceptance and coefficient write in IDLE: the write lands first, and the new coefficient is used for the accepted sample.
REQ-029 data_o and ovf_o SHALL hold their last values while out_valid_o is low.

Reset
REQ-030 rst high SHALL immediately force: state IDLE, in_ready_o 1 (0 while rst high), busy_o 0, out_valid_o 0, data_o 0, ovf_o 0, accumulator 0, idx 0, all delay-line entries 0, all coefficients 0.
REQ-031 Reset during MAC SHALL abort the computation with no out_valid_o pulse; the first edge after release finds the block in IDLE.

Verification
REQ-032 Impulse: WIDTH=16, TAPS=4, FRAC=15, coefs {16384,8192,4096,-4096}; samples 16384,0,0,0,0 -> data_o 8192,4096,2048,-2048,0, ovf_o 0, each pulse 4 cycles after acceptance.
REQ-033 Saturation: TAPS=4, FRAC=15, all coefs 32767; feed 32767 four times -> last output 32767, ovf_o 1; then -32768 four times -> -32768, ovf_o 1.
REQ-034 Rounding: FRAC=1, coef0=1, others 0; sample 3 -> 2; sample -3 -> -1; sample 1 -> 1; sample -1 -> 0.
REQ-035 Busy rules: write coef0=100 during MAC -> ignored (next result uses old coef); hold in_valid_i through MAC -> exactly one acceptance per TAPS+1 cycles.
REQ-036 Reset mid-MAC: assert rst at idx=2 -> no out_valid_o pulse, all outputs 0; after release, impulse 16384 with coefs unwritten -> output 0.
REQ-037 Write-and-accept same edge: coef0=32767 written together with sample 16384 accepted (FRAC=15) -> first output 16384.
